// File: rtl/count_cmd_seq.sv
// rtl/count_cmd_seq.sv - command-driven sequencer and checker for the reloadable up/down counter
//
// Accepts one command at a time (start value, step count, direction), loads the counter, lets it
// count for the programmed number of cycles and compares its count output every cycle against an
// internal model of the counter, then pulses o_done.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_reset_async  asynchronous active-high reset
//   i_cmd_valid    command present
//   o_cmd_ready    command accepted when high (IDLE decode)
//   i_cmd_start    start/reload value for the counter
//   i_cmd_steps    number of counting cycles N
//   i_cmd_up       direction, 1 = up, 0 = down
//   o_load         counter load strobe
//   o_load_val     counter load value (holds last start value)
//   o_up           counter direction (holds last command's direction)
//   i_count        counter's registered count output
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse at end of command
//   o_err          sticky mismatch flag for current/last command
module count_cmd_seq #(
  parameter int DATA_WIDTH = 4,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_async,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_cmd_start,
  input  logic [STEP_WIDTH-1:0] i_cmd_steps,
  input  logic                  i_cmd_up,
  output logic                  o_load,
  output logic [DATA_WIDTH-1:0] o_load_val,
  output logic                  o_up,
  input  logic [DATA_WIDTH-1:0] i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] start_q, start_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic                  up_q, up_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [STEP_WIDTH-1:0] rem_q, rem_d;
  logic                  err_q, err_d;
  logic                  load_q, load_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  mismatch;
  logic                  exp_wrap;
  logic [DATA_WIDTH-1:0] exp_next;

  assign accept = (state_q == S_IDLE) && i_cmd_valid;

  // Model of the counter: at the terminal value it reloads the start value instead of rolling over.
  assign exp_wrap = up_q ? (exp_q == {DATA_WIDTH{1'b1}}) : (exp_q == {DATA_WIDTH{1'b0}});
  assign exp_next = exp_wrap ? start_q
                  : (up_q ? exp_q + DATA_WIDTH'(1) : exp_q - DATA_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    steps_d  = steps_q;
    up_d     = up_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    load_d   = 1'b0;
    done_d   = 1'b0;
    mismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          start_d = i_cmd_start;
          steps_d = i_cmd_steps;
          up_d    = i_cmd_up;
          state_d = S_LOAD;
          load_d  = 1'b1;
        end
      end
      S_LOAD: begin
        exp_d = start_q;
        rem_d = steps_q;
        if (steps_q == {STEP_WIDTH{1'b0}}) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        mismatch = (i_count != exp_q);
        exp_d    = exp_next;
        rem_d    = rem_q - STEP_WIDTH'(1);
        if (rem_q == STEP_WIDTH'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        // exp_q has advanced N times by now, i.e. it holds the final expected count
        mismatch = (i_count != exp_q);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance clears the flag; otherwise it is sticky.
    err_d = accept ? 1'b0 : (err_q | mismatch);
  end

  always_ff @(posedge i_clk or posedge i_reset_async) begin
    if (i_reset_async) begin
      state_q <= S_IDLE;
      start_q <= '0;
      steps_q <= '0;
      up_q    <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      steps_q <= steps_d;
      up_q    <= up_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_load      = load_q;
  assign o_load_val  = start_q;
  assign o_up        = up_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_count_cmd_seq.sv
// tb/tb_count_cmd_seq.sv - self-checking bench for count_cmd_seq
module tb_count_cmd_seq;
  localparam int DW = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [DW-1:0] i_cmd_start = '0;
  logic [SW-1:0] i_cmd_steps = '0;
  logic          i_cmd_up = 1'b0;
  logic          o_load;
  logic [DW-1:0] o_load_val;
  logic          o_up;
  logic [DW-1:0] i_count;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int total = 0;
  int bad   = 0;

  count_cmd_seq #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .i_clk(clk), .i_reset_async(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_start(i_cmd_start), .i_cmd_steps(i_cmd_steps), .i_cmd_up(i_cmd_up),
    .o_load(o_load), .o_load_val(o_load_val), .o_up(o_up),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Counter under control; its output can be overridden for one cycle to inject a mismatch.
  logic [DW-1:0] cnt;
  logic          cor_en = 1'b0;
  logic [DW-1:0] cor_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (o_load) cnt <= o_load_val;
    else if (o_up) cnt <= (cnt == 4'hF) ? o_load_val : cnt + 4'd1;
    else cnt <= (cnt == 4'h0) ? o_load_val : cnt - 4'd1;
  end
  assign i_count = cor_en ? cor_val : cnt;

  typedef struct {
    int start;
    int steps;
    bit up;
    int cor_idx;   // compare index to corrupt (0..steps), -1 for none
    int cor_val;
    bit exp_err;   // o_err expected once back in IDLE
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // j-th value the counter shows after a load of start (period ends at the terminal value).
  function automatic int ref_val(input int start, input bit up, input int j);
    int len;
    if (up) begin
      len = (1 << DW) - start;
      return start + (j % len);
    end else begin
      len = start + 1;
      return start - (j % len);
    end
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    bit e;
    n = v.steps;
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_start = DW'(v.start);
    i_cmd_steps = SW'(v.steps);
    i_cmd_up    = v.up;
    @(negedge clk);
    chk({tag, " ready_at_accept"}, int'(o_cmd_ready), 1);
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
      cor_en  = (v.cor_idx >= 0) && (k == v.cor_idx + 2);
      cor_val = DW'(v.cor_val);
      @(negedge clk);
      e = (v.cor_idx >= 0) && (k >= v.cor_idx + 3);
      chk($sformatf("%s load k=%0d", tag, k),  int'(o_load),  int'(k == 1));
      chk($sformatf("%s done k=%0d", tag, k),  int'(o_done),  int'(k == n + 2));
      chk($sformatf("%s busy k=%0d", tag, k),  int'(o_busy),  int'(k <= n + 2));
      chk($sformatf("%s ready k=%0d", tag, k), int'(o_cmd_ready), int'(k == n + 3));
      chk($sformatf("%s up k=%0d", tag, k),    int'(o_up),    int'(v.up));
      chk($sformatf("%s lval k=%0d", tag, k),  int'(o_load_val), v.start);
      chk($sformatf("%s err k=%0d", tag, k),   int'(o_err),   int'(e));
    end
    cor_en = 1'b0;
    chk({tag, " err_final"}, int'(o_err), int'(v.exp_err));
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{13, 5, 1'b1, -1, 0, 1'b0};   // up with wrap D,E,F,D,E,F
    tbl[1] = '{2, 4, 1'b0, -1, 0, 1'b0};    // down with wrap 2,1,0,2,1
    tbl[2] = '{7, 0, 1'b1, -1, 0, 1'b0};    // zero steps
    tbl[3] = '{3, 5, 1'b1, 2, 0, 1'b1};     // 5 expected at index 2, forced to 0
    tbl[4] = '{9, 3, 1'b0, -1, 0, 1'b0};    // next command clears the flag
    tbl[5] = '{0, 3, 1'b0, 3, 9, 1'b1};     // mismatch in the DONE compare
    tbl[6] = '{15, 255, 1'b0, -1, 0, 1'b0}; // maximum step count

    // Reset state, with a command presented during reset that must be dropped.
    i_cmd_valid = 1'b1;
    i_cmd_start = 4'h6;
    i_cmd_steps = 8'd2;
    #12;
    chk("rst ready", int'(o_cmd_ready), 1);
    chk("rst busy",  int'(o_busy), 0);
    chk("rst load",  int'(o_load), 0);
    chk("rst done",  int'(o_done), 0);
    chk("rst err",   int'(o_err), 0);
    chk("rst up",    int'(o_up), 0);
    chk("rst lval",  int'(o_load_val), 0);
    @(negedge clk);
    rst = 1'b0;
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst dropped busy", int'(o_busy), 0);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv.start = $urandom_range(0, 15);
      rv.steps = $urandom_range(0, 20);
      rv.up    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        rv.cor_idx = $urandom_range(0, rv.steps);
        rv.cor_val = ref_val(rv.start, rv.up, rv.cor_idx) ^ int'($urandom_range(1, 15));
      end else begin
        rv.cor_idx = -1;
        rv.cor_val = 0;
      end
      rv.exp_err = (rv.cor_idx >= 0);
      run_cmd(rv, $sformatf("rnd%0d", i));
    end

    // Backpressure: B held valid while A runs, captured only at the first IDLE cycle.
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_start = 4'h3;
    i_cmd_steps = 8'd3;
    i_cmd_up    = 1'b1;
    @(posedge clk); #1;
    i_cmd_start = 4'hA;
    i_cmd_steps = 8'd0;
    i_cmd_up    = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp ready k=%0d", k), int'(o_cmd_ready), 0);
      chk($sformatf("bp lval k=%0d", k),  int'(o_load_val), 3);
      chk($sformatf("bp up k=%0d", k),    int'(o_up), 1);
      chk($sformatf("bp done k=%0d", k),  int'(o_done), int'(k == 5));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp ready idle", int'(o_cmd_ready), 1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp B load", int'(o_load), 1);
    chk("bp B lval", int'(o_load_val), 10);
    chk("bp B up",   int'(o_up), 0);
    @(negedge clk);
    chk("bp B done", int'(o_done), 1);
    @(negedge clk);
    chk("bp B ready", int'(o_cmd_ready), 1);
    chk("bp B err",   int'(o_err), 0);

    // Reset in the third STEP cycle, with o_err already set.
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_start = 4'h5;
    i_cmd_steps = 8'd6;
    i_cmd_up    = 1'b1;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    cor_en  = 1'b1;
    cor_val = 4'h0;
    @(posedge clk); #1;
    cor_en = 1'b0;
    @(negedge clk);
    chk("mr err set", int'(o_err), 1);
    chk("mr busy",    int'(o_busy), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    i_cmd_valid = 1'b1;
    #1;
    chk("mr busy drop",  int'(o_busy), 0);
    chk("mr load drop",  int'(o_load), 0);
    chk("mr done drop",  int'(o_done), 0);
    chk("mr err drop",   int'(o_err), 0);
    chk("mr ready",      int'(o_cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("mr post ready", int'(o_cmd_ready), 1);
    chk("mr post up",    int'(o_up), 0);
    chk("mr post busy",  int'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
